// File: rtl/sata_link_ctrl_if.sv
// sata_link_ctrl_if
// Groups the link bring-up controller's control and status signals.
//   master : the controller side (sata_link_ctrl)
//   slave  : the environment side (port layer, OOB block, DRP rate logic)
// Inputs to the controller:
//   enable, restart, force_gen1   - port layer controls
//   link_up, CommInit             - from the OOB block
//   reconfig_ack                  - one-cycle completion pulse from DRP logic
// Outputs from the controller:
//   StartComm                     - COMRESET request to the OOB block
//   gen2_sel, reconfig_req        - line rate select and rate-change request
//   link_ready, fail, tries       - status to the port layer
//   state_o                       - current state code, debug only
interface sata_link_ctrl_if;
   logic       enable;
   logic       restart;
   logic       force_gen1;
   logic       link_up;
   logic       CommInit;
   logic       reconfig_ack;
   logic       StartComm;
   logic       gen2_sel;
   logic       reconfig_req;
   logic       link_ready;
   logic       fail;
   logic [3:0] tries;
   logic [2:0] state_o;

   modport master (
      input  enable, restart, force_gen1, link_up, CommInit, reconfig_ack,
      output StartComm, gen2_sel, reconfig_req, link_ready, fail, tries, state_o
   );

   modport slave (
      output enable, restart, force_gen1, link_up, CommInit, reconfig_ack,
      input  StartComm, gen2_sel, reconfig_req, link_ready, fail, tries, state_o
   );
endinterface

// File: rtl/sata_link_ctrl.sv
// sata_link_ctrl
// SATA host link bring-up sequencer. Pulses StartComm (COMRESET) into the OOB
// block, supervises link_up with a timeout, debounces it into link_ready,
// retries a bounded number of times per speed and falls back from GEN2 to GEN1
// through a request/ack rate change with the DRP logic.
// Ports:
//   sys_clk    - clock (OOB block txusrclk domain)
//   sys_rst_n  - asynchronous active-low reset
//   lnk        - sata_link_ctrl_if.master (controls in, status out)
// All outputs are flops loaded from the next-state decode, so they change on
// the same edge as the state register.
//
// state       | code | meaning
// S_OFF       |  0   | port disabled, OOB held in COMRESET
// S_RECONFIG  |  1   | rate change requested, waiting for reconfig_ack
// S_COMRESET  |  2   | StartComm held high for C_COMRESET_HOLD cycles
// S_WAIT_LINK |  3   | StartComm released, waiting for link_up or timeout
// S_STABLE    |  4   | link_up seen, must stay high C_LINK_STABLE cycles
// S_READY     |  5   | link usable, link_ready high
// S_FAIL      |  6   | all attempts at all speeds exhausted
module sata_link_ctrl #(
   parameter int          C_COMRESET_HOLD = 16,
   parameter logic [23:0] C_LINK_TIMEOUT  = 24'd3000000,
   parameter logic [23:0] C_LINK_STABLE   = 24'd1024,
   parameter int          C_MAX_TRIES     = 4
) (
   input logic              sys_clk,
   input logic              sys_rst_n,
   sata_link_ctrl_if.master lnk
);

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_RECONFIG  = 3'd1,
      S_COMRESET  = 3'd2,
      S_WAIT_LINK = 3'd3,
      S_STABLE    = 3'd4,
      S_READY     = 3'd5,
      S_FAIL      = 3'd6
   } state_t;

   localparam logic [23:0] HOLD_LAST    = 24'(C_COMRESET_HOLD - 1);
   localparam logic [23:0] TIMEOUT_LAST = C_LINK_TIMEOUT - 24'd1;
   localparam logic [23:0] STABLE_LAST  = C_LINK_STABLE - 24'd1;
   localparam logic [3:0]  MAX_TRIES    = 4'(C_MAX_TRIES);

   state_t      state_q, state_d;
   logic [23:0] timer_q, timer_d;
   logic [3:0]  tries_q, tries_d;
   logic        gen2_sel_q, gen2_sel_d;
   logic        fail_q, fail_d;
   logic        start_comm_q, start_comm_d;
   logic        reconfig_req_q, reconfig_req_d;
   logic        link_ready_q, link_ready_d;
   logic [3:0]  tries_inc;
   logic        attempt_failed;
   logic        timer_run;

   always_comb begin
      tries_inc = (tries_q >= MAX_TRIES) ? MAX_TRIES : tries_q + 4'd1;
   end

   always_comb begin
      state_d        = state_q;
      tries_d        = tries_q;
      gen2_sel_d     = gen2_sel_q;
      fail_d         = fail_q;
      attempt_failed = 1'b0;

      if (!lnk.enable) begin
         state_d = S_OFF;
         tries_d = 4'd0;
         fail_d  = 1'b0;
      end else if (lnk.restart && (state_q != S_OFF)) begin
         // also wins over a coincident reconfig_ack: the handshake starts over
         state_d    = S_RECONFIG;
         tries_d    = 4'd0;
         fail_d     = 1'b0;
         gen2_sel_d = ~lnk.force_gen1;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d    = S_RECONFIG;
               gen2_sel_d = ~lnk.force_gen1;
            end
            S_RECONFIG: begin
               if (lnk.reconfig_ack) state_d = S_COMRESET;
            end
            S_COMRESET: begin
               if (timer_q == HOLD_LAST) state_d = S_WAIT_LINK;
            end
            S_WAIT_LINK: begin
               // link_up beats a coincident timeout
               if (lnk.link_up) state_d = S_STABLE;
               else if (timer_q == TIMEOUT_LAST) attempt_failed = 1'b1;
            end
            S_STABLE: begin
               if (!lnk.link_up) begin
                  attempt_failed = 1'b1;
               end else if (timer_q == STABLE_LAST) begin
                  state_d = S_READY;
                  tries_d = 4'd0;
               end
            end
            S_READY: begin
               if (!lnk.link_up || lnk.CommInit) begin
                  state_d = S_COMRESET;
                  tries_d = 4'd0;
               end
            end
            S_FAIL: begin
               state_d = S_FAIL;
            end
            default: begin
               state_d = S_OFF;
            end
         endcase

         if (attempt_failed) begin
            tries_d = tries_inc;
            if (tries_inc < MAX_TRIES) begin
               state_d = S_COMRESET;
            end else if (gen2_sel_q) begin
               gen2_sel_d = 1'b0;
               tries_d    = 4'd0;
               state_d    = S_RECONFIG;
            end else begin
               state_d = S_FAIL;
               fail_d  = 1'b1;
            end
         end
      end

      // timer restarts from zero on every state change, including a failed
      // attempt that re-enters S_COMRESET from S_WAIT_LINK/S_STABLE
      timer_run = (state_q == S_COMRESET) || (state_q == S_WAIT_LINK) ||
                  (state_q == S_STABLE);
      if (state_d != state_q) timer_d = 24'd0;
      else if (timer_run)     timer_d = timer_q + 24'd1;
      else                    timer_d = timer_q;

      start_comm_d   = (state_d == S_OFF) || (state_d == S_RECONFIG) ||
                       (state_d == S_COMRESET) || (state_d == S_FAIL);
      reconfig_req_d = (state_d == S_RECONFIG);
      link_ready_d   = (state_d == S_READY);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q        <= S_OFF;
         timer_q        <= 24'd0;
         tries_q        <= 4'd0;
         gen2_sel_q     <= 1'b1;
         fail_q         <= 1'b0;
         start_comm_q   <= 1'b1;
         reconfig_req_q <= 1'b0;
         link_ready_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         tries_q        <= tries_d;
         gen2_sel_q     <= gen2_sel_d;
         fail_q         <= fail_d;
         start_comm_q   <= start_comm_d;
         reconfig_req_q <= reconfig_req_d;
         link_ready_q   <= link_ready_d;
      end
   end

   assign lnk.StartComm    = start_comm_q;
   assign lnk.gen2_sel     = gen2_sel_q;
   assign lnk.reconfig_req = reconfig_req_q;
   assign lnk.link_ready   = link_ready_q;
   assign lnk.fail         = fail_q;
   assign lnk.tries        = tries_q;
   assign lnk.state_o      = state_q;

endmodule
